// File: rtl/pace_fifo.sv
// pace_fifo: DEPTH-entry synchronous FIFO holding items waiting for a release
// credit. Storage is write-only-on-push and intentionally has no reset; only
// the pointers and occupancy count are cleared.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push           write push_data (ignored when full)
//   push_data      payload to store
//   pop            advance the read pointer (ignored when empty)
//   pop_data       payload at the head, valid whenever !empty
//   full, empty    occupancy flags from registered count only
module pace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pace_buffer.sv
// pace_buffer: rate-paced release buffer. Items are queued in pace_fifo and
// moved into a single output register only when a release credit is
// available, either banked from an earlier tick or supplied by a tick in the
// current cycle. At most one credit is banked.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   tick                 one-cycle rate strobe from the period counter
//   clear                asks the period counter to restart its period
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload
module pace_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    output logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             credit_q, credit_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             push;
    logic             load;

    // in_ready comes from registered occupancy only, so a pop in the same
    // cycle never opens a slot for a same-cycle push.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    // The FIFO count is registered, so an item pushed this cycle cannot be
    // loaded before the next one.
    assign load = (credit_q || tick) && !fifo_empty && (!out_valid_q || out_ready);

    // A release driven by this cycle's tick leaves the period running; only a
    // release that spends a banked credit restarts it.
    assign clear = load && !tick;

    pace_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (load),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        // A load spends one credit: the banked one if present, else the tick.
        // With both present the tick stays banked; saturation drops extras.
        if (load) begin
            credit_d = credit_q && tick;
        end else begin
            credit_d = credit_q || tick;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_head;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            credit_q    <= credit_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
